// File: rtl/fruit_pkg.sv
// fruit_pkg: shared types and constants for the fruit motion pool.
//   - Screen limits used by the retire test.
//   - Storage widths of one slot record (fruit_slot_t).
//   - FSM state type for the update sweep.
//   - off_screen(): retire test applied to an already-moved centre.
// The top-level POS_W / V_W parameters must match FP_POS_W / FP_V_W, since
// the slot record is sized from these constants.
package fruit_pkg;

  localparam int SCREEN_MAX_X = 639;
  localparam int SCREEN_MAX_Y = 479;

  localparam int FP_POS_W = 12;
  localparam int FP_V_W   = 8;
  localparam int FP_CNT_W = 8;   // gravity / rotation divider counters, DIV <= 256
  localparam int FP_ROT_W = 8;   // rotation index storage, ROT_STEPS <= 256

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_t;

  typedef struct packed {
    logic signed [FP_POS_W-1:0] x;
    logic signed [FP_POS_W-1:0] y;
    logic signed [FP_V_W-1:0]   vx;
    logic signed [FP_V_W-1:0]   vy;
    logic [FP_CNT_W-1:0]        gcnt;
    logic [FP_CNT_W-1:0]        rcnt;
    logic [FP_ROT_W-1:0]        rot;
    logic                       active;
  } fruit_slot_t;

  // Centre coordinates are the one-bit-wider sums, so a fruit that has just
  // crossed the representable range is still judged correctly.
  function automatic logic off_screen(input logic signed [FP_POS_W:0] x,
                                      input logic signed [FP_POS_W:0] y,
                                      input int                       radius);
    return (int'(y) > SCREEN_MAX_Y + radius) ||
           (int'(x) > SCREEN_MAX_X + radius) ||
           (int'(x) + radius <= 0);
  endfunction

endpackage

// File: rtl/fruit_slot_update.sv
// fruit_slot_update: combinational one-frame update of a single fruit slot.
//   cur : slot record before the frame
//   nxt : slot record after the frame (move, gravity, rotation, retire)
// Inactive slots pass through unchanged. Rotation logic is only built when
// FRUIT_POOL_ROT_EN is defined; otherwise rcnt/rot are carried untouched.
module fruit_slot_update
  import fruit_pkg::*;
#(
  parameter int RADIUS      = 32,
  parameter int GRAVITY_DIV = 8
`ifdef FRUIT_POOL_ROT_EN
  ,
  parameter int ROT_DIV     = 2,
  parameter int ROT_STEPS   = 32
`endif
) (
  input  fruit_slot_t cur,
  output fruit_slot_t nxt
);

  localparam logic signed [FP_V_W-1:0] VY_MAX = {1'b0, {(FP_V_W-1){1'b1}}};

  function automatic logic signed [FP_V_W-1:0] sat_inc_vy(input logic signed [FP_V_W-1:0] v);
    return (v == VY_MAX) ? v : v + FP_V_W'(1);
  endfunction

  logic signed [FP_POS_W:0] x_sum;
  logic signed [FP_POS_W:0] y_sum;

  assign x_sum = $signed({cur.x[FP_POS_W-1], cur.x}) +
                 $signed({{(FP_POS_W+1-FP_V_W){cur.vx[FP_V_W-1]}}, cur.vx});
  assign y_sum = $signed({cur.y[FP_POS_W-1], cur.y}) +
                 $signed({{(FP_POS_W+1-FP_V_W){cur.vy[FP_V_W-1]}}, cur.vy});

`ifdef FRUIT_POOL_ROT_EN
  localparam logic [FP_ROT_W-1:0] ROT_MASK = FP_ROT_W'(ROT_STEPS - 1);
`endif

  always_comb begin
    nxt = cur;
    if (cur.active) begin
      nxt.x = x_sum[FP_POS_W-1:0];
      nxt.y = y_sum[FP_POS_W-1:0];

      if (cur.gcnt == FP_CNT_W'(GRAVITY_DIV - 1)) begin
        nxt.vy   = sat_inc_vy(cur.vy);
        nxt.gcnt = '0;
      end else begin
        nxt.gcnt = cur.gcnt + FP_CNT_W'(1);
      end

`ifdef FRUIT_POOL_ROT_EN
      if (cur.rcnt == FP_CNT_W'(ROT_DIV - 1)) begin
        nxt.rcnt = '0;
        // Spin direction follows horizontal travel; vx is unchanged by the update.
        if (!cur.vx[FP_V_W-1]) nxt.rot = (cur.rot + FP_ROT_W'(1)) & ROT_MASK;
        else                   nxt.rot = (cur.rot - FP_ROT_W'(1)) & ROT_MASK;
      end else begin
        nxt.rcnt = cur.rcnt + FP_CNT_W'(1);
      end
`endif

      nxt.active = !off_screen(x_sum, y_sum, RADIUS);
    end
  end

endmodule

// File: rtl/fruit_motion_pool.sv
// fruit_motion_pool: multi-slot fruit kinematics engine.
//   Clk, Reset_n (async, active-low)
//   frame_clk_rising_edge : frame tick; starts a sweep updating one slot/clock
//   spawn_valid/spawn_ready, spawn_x/y/vx/vy, spawn_slot : spawn handshake
//   slice_valid, slice_slot : kill a slot
//   DrawX, DrawY : pixel being drawn; hit_mask is registered one cycle later
//   active, slot_x, slot_y, slot_rot : per-slot state to the renderer
//   busy : sweep in progress; frame_overrun : sticky, tick arrived while busy
// Optional feature macro: FRUIT_POOL_ROT_EN (rotation); undefined ties slot_rot to 0.
module fruit_motion_pool
  import fruit_pkg::*;
#(
  parameter int N_SLOTS     = 4,
  parameter int POS_W       = FP_POS_W,
  parameter int V_W         = FP_V_W,
  parameter int RADIUS      = 32,
  parameter int GRAVITY_DIV = 8,
  parameter int ROT_DIV     = 2,
  parameter int ROT_STEPS   = 32,
  localparam int SLOT_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
  localparam int ROT_W      = $clog2(ROT_STEPS)
) (
  input  logic                                Clk,
  input  logic                                Reset_n,
  input  logic                                frame_clk_rising_edge,
  input  logic                                spawn_valid,
  output logic                                spawn_ready,
  input  logic signed [POS_W-1:0]             spawn_x,
  input  logic signed [POS_W-1:0]             spawn_y,
  input  logic signed [V_W-1:0]               spawn_vx,
  input  logic signed [V_W-1:0]               spawn_vy,
  output logic [SLOT_W-1:0]                   spawn_slot,
  input  logic                                slice_valid,
  input  logic [SLOT_W-1:0]                   slice_slot,
  input  logic [9:0]                          DrawX,
  input  logic [9:0]                          DrawY,
  output logic [N_SLOTS-1:0]                  active,
  output logic [N_SLOTS-1:0][POS_W-1:0]       slot_x,
  output logic [N_SLOTS-1:0][POS_W-1:0]       slot_y,
  output logic [N_SLOTS-1:0][ROT_W-1:0]       slot_rot,
  output logic [N_SLOTS-1:0]                  hit_mask,
  output logic                                busy,
  output logic                                frame_overrun
);

  localparam logic signed [2*POS_W+1:0] R_SQ = (2*POS_W+2)'(RADIUS * RADIUS);

  sweep_state_t      state, state_n;
  logic [SLOT_W-1:0] idx, idx_n;
  fruit_slot_t       slots [N_SLOTS];
  fruit_slot_t       upd_cur, upd_nxt, spawn_rec;
  logic              spawn_fire;
  logic [N_SLOTS-1:0] hit_nxt;

  function automatic logic signed [2*POS_W+1:0] sq(input logic signed [POS_W:0] d);
    logic signed [2*POS_W+1:0] e;
    e = {{(POS_W+1){d[POS_W]}}, d};
    return e * e;
  endfunction

  function automatic logic covers(input logic signed [POS_W-1:0] cx,
                                  input logic signed [POS_W-1:0] cy,
                                  input logic [9:0]              px,
                                  input logic [9:0]              py);
    logic signed [POS_W:0] dx, dy;
    dx = $signed({{(POS_W-9){1'b0}}, px}) - $signed({cx[POS_W-1], cx});
    dy = $signed({{(POS_W-9){1'b0}}, py}) - $signed({cy[POS_W-1], cy});
    return (sq(dx) + sq(dy)) <= R_SQ;
  endfunction

  assign busy = (state == ST_SWEEP);

  // ---- sweep control: state and slot index registers ----
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      frame_overrun <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (frame_clk_rising_edge && busy) frame_overrun <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      ST_IDLE: begin
        if (frame_clk_rising_edge) begin
          state_n = ST_SWEEP;
          idx_n   = '0;
        end
      end
      ST_SWEEP: begin
        if (idx == SLOT_W'(N_SLOTS - 1)) begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx + SLOT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // ---- shared update datapath, fed by the slot under the sweep index ----
  always_comb begin
    upd_cur = slots[0];
    for (int i = 1; i < N_SLOTS; i++) begin
      if (idx == SLOT_W'(i)) upd_cur = slots[i];
    end
  end

  fruit_slot_update #(
    .RADIUS      (RADIUS),
    .GRAVITY_DIV (GRAVITY_DIV)
`ifdef FRUIT_POOL_ROT_EN
    ,
    .ROT_DIV     (ROT_DIV),
    .ROT_STEPS   (ROT_STEPS)
`endif
  ) u_update (
    .cur (upd_cur),
    .nxt (upd_nxt)
  );

  // ---- spawn allocation ----
  always_comb begin
    spawn_slot = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) spawn_slot = SLOT_W'(i);
    end
  end

  assign spawn_ready = !busy && !(&active);
  assign spawn_fire  = spawn_valid && spawn_ready;

  // rcnt starts at its terminal value so the very first frame rotates.
  always_comb begin
    spawn_rec        = '0;
    spawn_rec.x      = spawn_x;
    spawn_rec.y      = spawn_y;
    spawn_rec.vx     = spawn_vx;
    spawn_rec.vy     = spawn_vy;
    spawn_rec.rcnt   = FP_CNT_W'(ROT_DIV - 1);
    spawn_rec.active = 1'b1;
  end

  // ---- slot state registers ----
  // Write order matters: a slice overrides the sweep write of the same slot,
  // and a spawn (only possible into an inactive slot) overrides a slice.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_SLOTS; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (busy && idx == SLOT_W'(i))                  slots[i]        <= upd_nxt;
        if (slice_valid && slice_slot == SLOT_W'(i))    slots[i].active <= 1'b0;
        if (spawn_fire && spawn_slot == SLOT_W'(i))     slots[i]        <= spawn_rec;
      end
    end
  end

  always_comb begin
    active   = '0;
    slot_x   = '0;
    slot_y   = '0;
    slot_rot = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      active[i] = slots[i].active;
      slot_x[i] = slots[i].x;
      slot_y[i] = slots[i].y;
`ifdef FRUIT_POOL_ROT_EN
      slot_rot[i] = slots[i].rot[ROT_W-1:0];
`endif
    end
  end

  // ---- hit test, registered toward the renderer ----
  always_comb begin
    hit_nxt = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      hit_nxt[i] = slots[i].active && covers(slots[i].x, slots[i].y, DrawX, DrawY);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) hit_mask <= '0;
    else          hit_mask <= hit_nxt;
  end

endmodule

// File: tb/tb_fruit_motion_pool.sv
module tb_fruit_motion_pool;

  localparam int N  = 4;
  localparam int PW = 12;
  localparam int VW = 8;
  localparam int R  = 32;
  localparam int GD = 8;
  localparam int RW = 5;
  localparam int SW = 2;
`ifdef FRUIT_POOL_ROT_EN
  localparam int RD = 2;
  localparam int RS = 32;
`endif

  logic                     Clk = 1'b0;
  logic                     Reset_n;
  logic                     tick;
  logic                     spawn_valid;
  logic                     spawn_ready;
  logic [PW-1:0]            spawn_x, spawn_y;
  logic [VW-1:0]            spawn_vx, spawn_vy;
  logic [SW-1:0]            spawn_slot;
  logic                     slice_valid;
  logic [SW-1:0]            slice_slot;
  logic [9:0]               DrawX, DrawY;
  logic [N-1:0]             active;
  logic [N-1:0][PW-1:0]     slot_x, slot_y;
  logic [N-1:0][RW-1:0]     slot_rot;
  logic [N-1:0]             hit_mask;
  logic                     busy;
  logic                     frame_overrun;

  fruit_motion_pool #(
    .N_SLOTS(N), .POS_W(PW), .V_W(VW), .RADIUS(R),
    .GRAVITY_DIV(GD), .ROT_DIV(2), .ROT_STEPS(32)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk_rising_edge(tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_vx(spawn_vx), .spawn_vy(spawn_vy),
    .spawn_slot(spawn_slot), .slice_valid(slice_valid), .slice_slot(slice_slot),
    .DrawX(DrawX), .DrawY(DrawY), .active(active), .slot_x(slot_x), .slot_y(slot_y),
    .slot_rot(slot_rot), .hit_mask(hit_mask), .busy(busy), .frame_overrun(frame_overrun)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_act [N];
  int m_x   [N];
  int m_y   [N];
  int m_vx  [N];
  int m_vy  [N];
  int m_g   [N];
  int m_rot [N];
`ifdef FRUIT_POOL_ROT_EN
  int m_r   [N];
`endif
  int m_overrun;

  typedef struct packed {
    logic [N-1:0]          act;
    logic [N-1:0][PW-1:0]  x;
    logic [N-1:0][PW-1:0]  y;
    logic [N-1:0][RW-1:0]  rot;
  } snap_t;

  snap_t       snap_q [$];
  logic [N-1:0] hit_q [$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
      m_g[i] = 0; m_rot[i] = 0;
`ifdef FRUIT_POOL_ROT_EN
      m_r[i] = 0;
`endif
    end
    m_overrun = 0;
  endtask

  function automatic int act_vec();
    int v = 0;
    for (int i = 0; i < N; i++) if (m_act[i] != 0) v |= (1 << i);
    return v;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < N; i++) if (m_act[i] == 0) return i;
    return -1;
  endfunction

  task automatic model_frame();
    int nx, ny;
    for (int i = 0; i < N; i++) begin
      if (m_act[i] != 0) begin
        nx = m_x[i] + m_vx[i];
        ny = m_y[i] + m_vy[i];
        if (m_g[i] == GD - 1 && m_vy[i] < 127) m_vy[i]++;
        m_g[i] = (m_g[i] + 1) % GD;
`ifdef FRUIT_POOL_ROT_EN
        if (m_r[i] == RD - 1) m_rot[i] = (m_rot[i] + ((m_vx[i] >= 0) ? 1 : RS - 1)) % RS;
        m_r[i] = (m_r[i] + 1) % RD;
`endif
        m_x[i] = nx;
        m_y[i] = ny;
        if (ny > 479 + R || nx > 639 + R || nx + R <= 0) m_act[i] = 0;
      end
    end
  endtask

  function automatic snap_t make_snap();
    snap_t s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s.act[i] = (m_act[i] != 0);
      s.x[i]   = PW'(m_x[i]);
      s.y[i]   = PW'(m_y[i]);
      s.rot[i] = RW'(m_rot[i]);
    end
    return s;
  endfunction

  function automatic logic [N-1:0] model_hits(input int px, input int py);
    logic [N-1:0] h;
    int dx, dy;
    h = '0;
    for (int i = 0; i < N; i++) begin
      dx = px - m_x[i];
      dy = py - m_y[i];
      h[i] = (m_act[i] != 0) && (dx * dx + dy * dy <= R * R);
    end
    return h;
  endfunction

  // ---------------- monitors ----------------
  logic prev_busy = 1'b0;
  int   busy_len  = 0;
  logic dv        = 1'b0;
  logic dv_d      = 1'b0;

  task automatic compare_snap(input snap_t e);
    chk("sweep_active", int'(active), int'(e.act));
    for (int i = 0; i < N; i++) begin
      if (e.act[i]) begin
        chk($sformatf("sweep_x[%0d]", i), int'(slot_x[i]), int'(e.x[i]));
        chk($sformatf("sweep_y[%0d]", i), int'(slot_y[i]), int'(e.y[i]));
        chk($sformatf("sweep_rot[%0d]", i), int'(slot_rot[i]), int'(e.rot[i]));
      end
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset_n) begin
      prev_busy <= 1'b0;
      busy_len  <= 0;
    end else begin
      if (busy) begin
        busy_len <= busy_len + 1;
      end else if (prev_busy) begin
        chk("sweep_len", busy_len, N);
        busy_len <= 0;
        if (snap_q.size() == 0) chk("snap_unexpected", 1, 0);
        else compare_snap(snap_q.pop_front());
      end
      prev_busy <= busy;
    end
  end

  always @(posedge Clk) dv_d <= dv;

  always @(negedge Clk) begin
    if (Reset_n && dv_d) begin
      if (hit_q.size() == 0) chk("hit_unexpected", 1, 0);
      else chk("hit_mask", int'(hit_mask), int'(hit_q.pop_front()));
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    if (busy) chk("sweep_timeout", 1, 0);
    step();
  endtask

  task automatic do_tick();
    model_frame();
    snap_q.push_back(make_snap());
    tick = 1'b1;
    step();
    tick = 1'b0;
    wait_idle();
  endtask

  task automatic do_spawn(input int x, input int y, input int vx, input int vy);
    int s;
    s = lowest_free();
    chk("spawn_ready", int'(spawn_ready), int'(s >= 0));
    if (s >= 0) begin
      chk("spawn_slot", int'(spawn_slot), s);
      spawn_x = PW'(x); spawn_y = PW'(y); spawn_vx = VW'(vx); spawn_vy = VW'(vy);
      spawn_valid = 1'b1;
      step();
      spawn_valid = 1'b0;
      m_act[s] = 1; m_x[s] = x; m_y[s] = y; m_vx[s] = vx; m_vy[s] = vy;
      m_g[s] = 0; m_rot[s] = 0;
`ifdef FRUIT_POOL_ROT_EN
      m_r[s] = RD - 1;
`endif
      chk("active_after_spawn", int'(active), act_vec());
    end
  endtask

  task automatic do_slice(input int s);
    slice_slot  = SW'(s);
    slice_valid = 1'b1;
    step();
    slice_valid = 1'b0;
    m_act[s] = 0;
    chk("active_after_slice", int'(active), act_vec());
  endtask

  task automatic probe(input int px, input int py);
    DrawX = 10'(px);
    DrawY = 10'(py);
    dv = 1'b1;
    hit_q.push_back(model_hits(px, py));
    step();
    dv = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int s, px, py;
    Reset_n = 1'b0; tick = 1'b0; spawn_valid = 1'b0; slice_valid = 1'b0;
    spawn_x = '0; spawn_y = '0; spawn_vx = '0; spawn_vy = '0;
    slice_slot = '0; DrawX = '0; DrawY = '0;
    model_reset();
    repeat (3) step();
    Reset_n = 1'b1;
    step();

    chk("rst_active", int'(active), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(frame_overrun), 0);
    chk("rst_ready", int'(spawn_ready), 1);
    chk("rst_hit", int'(hit_mask), 0);
    chk("rst_slot_x0", int'(slot_x[0]), 0);

    // first fruit and its first frames
    do_spawn(320, 400, 2, -8);
    do_tick();
    chk("x0_after_tick", int'(slot_x[0]), 322);
    chk("y0_after_tick", int'(slot_y[0]), 392);
    repeat (8) do_tick();

    // fill the pool, then free slot 2
    do_spawn(200, 300, 1, -5);
    do_spawn(400, 250, -2, -6);
    do_spawn(500, 350, 0, -4);
    chk("ready_full", int'(spawn_ready), int'(lowest_free() >= 0));
    do_spawn(10, 10, 0, 0);
    do_slice(2);
    chk("ready_after_slice", int'(spawn_ready), 1);
    chk("slot_after_slice", int'(spawn_slot), 2);
    do_spawn(300, 200, -1, -3);
    do_tick();

    // slice slot 1 during the cycle it is swept
    model_frame();
    m_act[1] = 0;
    snap_q.push_back(make_snap());
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    slice_slot = SW'(1);
    slice_valid = 1'b1;
    step();
    slice_valid = 1'b0;
    wait_idle();

    // second tick two cycles after the first is dropped
    chk("overrun_before", int'(frame_overrun), m_overrun);
    model_frame();
    snap_q.push_back(make_snap());
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    m_overrun = 1;
    wait_idle();
    chk("overrun_after", int'(frame_overrun), m_overrun);

    // hit test boundary
    for (int i = 0; i < N; i++) if (m_act[i] != 0) do_slice(i);
    do_spawn(100, 132, 0, 0);
    do_spawn(100, 133, 0, 0);
    probe(100, 100);
    probe(100, 101);

    // leftward retire
    do_spawn(-30, 200, -3, 0);
    do_tick();
    probe(0, 200);
    probe(100, 100);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(0, 2)) begin
        do_spawn(int'($urandom_range(40, 600)), int'($urandom_range(100, 470)),
                 int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 20)) - 14);
      end
      if ($urandom_range(0, 2) == 0) do_slice(int'($urandom_range(0, N - 1)));
      repeat (2) begin
        s = int'($urandom_range(0, N - 1));
        if (m_act[s] != 0) begin
          px = m_x[s] + int'($urandom_range(0, 80)) - 40;
          py = m_y[s] + int'($urandom_range(0, 80)) - 40;
        end else begin
          px = int'($urandom_range(0, 639));
          py = int'($urandom_range(0, 479));
        end
        if (px < 0) px = 0;
        if (px > 1023) px = 1023;
        if (py < 0) py = 0;
        if (py > 1023) py = 1023;
        probe(px, py);
      end
      do_tick();
    end

    // reset in the middle of a sweep
    if (lowest_free() >= 0) do_spawn(300, 300, 1, -1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    Reset_n = 1'b0;
    step();
    model_reset();
    chk("midrst_active", int'(active), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_overrun", int'(frame_overrun), 0);
    chk("midrst_xy", int'(|{slot_x, slot_y, slot_rot}), 0);
    Reset_n = 1'b1;
    step();
    do_spawn(300, 300, 1, -1);
    do_tick();

    repeat (4) step();
    chk("snap_q_drained", snap_q.size(), 0);
    chk("hit_q_drained", hit_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
